factorial_ctrl: RTL and testbench

- Control FSM that sequences the factorial datapath; it is the command side of the datapath's control interface.
- Drives register-select, ALU-op and write-enable lines. Samples the datapath zero/compare flag `z`.
- Re-initialises the datapath through a dedicated reset line before each run.
- Returns the finished product to a consumer over a valid/ready handshake, with an iteration guard that flags non-terminating runs.

---
 rtl/factorial_ctrl_if.sv | 34 +++
 rtl/factorial_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_factorial_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/factorial_ctrl_if.sv
// Control/handshake bundle between the factorial controller, its datapath and the result consumer.
interface factorial_ctrl_if #(
    parameter int unsigned ITER_W = 6
);
    logic              start;
    logic              z;
    logic [31:0]       dp_result;
    logic              dp_rst;
    logic [1:0]        a_sel;
    logic [1:0]        b_sel;
    logic              w_sel;
    logic              w_en;
    logic              op_sel;
    logic              busy;
    logic [31:0]       result;
    logic              result_valid;
    logic              result_ready;
    logic              err;
    logic [ITER_W-1:0] iter_count;

    // Controller side
    modport master (
        input  start, z, dp_result, result_ready,
        output dp_rst, a_sel, b_sel, w_sel, w_en, op_sel,
               busy, result, result_valid, err, iter_count
    );

    // Datapath / requester / consumer side
    modport slave (
        output start, z, dp_result, result_ready,
        input  dp_rst, a_sel, b_sel, w_sel, w_en, op_sel,
               busy, result, result_valid, err, iter_count
    );
endinterface

// File: rtl/factorial_ctrl.sv
// Factorial sequencer: resets the datapath, loops CHECK/MUL/DEC until x1 == 1,
// then hands the product to a consumer; aborts with err after MAX_ITER iterations.
module factorial_ctrl #(
    parameter int unsigned MAX_ITER = 32,
    parameter int unsigned ITER_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    factorial_ctrl_if.master bus
);
    localparam int unsigned DATA_W = 32;
    localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        CHECK = 3'd2,
        MUL   = 3'd3,
        DEC   = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_result;
    logic [DATA_W-1:0]   w_result_nxt;
    logic                r_result_valid;
    logic                w_result_valid_nxt;
    logic                r_err;
    logic                w_err_nxt;
    logic [ITER_W-1:0]   r_iter_count;
    logic [ITER_W-1:0]   w_iter_count_nxt;

    logic                r_dp_rst;
    logic                w_dp_rst_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_w_en;
    logic                w_w_en_nxt;
    logic [1:0]          r_a_sel;
    logic [1:0]          w_a_sel_nxt;
    logic [1:0]          r_b_sel;
    logic [1:0]          w_b_sel_nxt;
    logic                r_op_sel;
    logic                w_op_sel_nxt;
    logic                r_w_sel;
    logic                w_w_sel_nxt;

    // State register plus all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;
            r_iter_count   <= '0;
            r_dp_rst       <= 1'b1;
            r_busy         <= 1'b0;
            r_w_en         <= 1'b0;
            r_a_sel        <= 2'd0;
            r_b_sel        <= 2'd0;
            r_op_sel       <= 1'b0;
            r_w_sel        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_result       <= w_result_nxt;
            r_result_valid <= w_result_valid_nxt;
            r_err          <= w_err_nxt;
            r_iter_count   <= w_iter_count_nxt;
            r_dp_rst       <= w_dp_rst_nxt;
            r_busy         <= w_busy_nxt;
            r_w_en         <= w_w_en_nxt;
            r_a_sel        <= w_a_sel_nxt;
            r_b_sel        <= w_b_sel_nxt;
            r_op_sel       <= w_op_sel_nxt;
            r_w_sel        <= w_w_sel_nxt;
        end
    end

    // Next-state, bookkeeping, and Moore decode of the upcoming state so outputs are flops
    always_comb begin
        w_state_nxt        = r_state;
        w_result_nxt       = r_result;
        w_result_valid_nxt = r_result_valid;
        w_err_nxt          = r_err;
        w_iter_count_nxt   = r_iter_count;
        w_dp_rst_nxt       = 1'b0;
        w_busy_nxt         = 1'b0;
        w_w_en_nxt         = 1'b0;
        w_a_sel_nxt        = 2'd0;
        w_b_sel_nxt        = 2'd0;
        w_op_sel_nxt       = 1'b0;
        w_w_sel_nxt        = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt      = INIT;
                    w_iter_count_nxt = '0;
                end
            end
            INIT: begin
                w_state_nxt = CHECK;
            end
            CHECK: begin
                // Completion beats the iteration guard when both hold
                if (bus.z) begin
                    w_state_nxt        = DONE;
                    w_result_nxt       = bus.dp_result;
                    w_result_valid_nxt = 1'b1;
                end else if (r_iter_count == ITER_MAX) begin
                    w_state_nxt = ERR;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_state_nxt = MUL;
                end
            end
            MUL: begin
                w_state_nxt = DEC;
                if (r_iter_count != ITER_MAX) begin
                    w_iter_count_nxt = r_iter_count + ITER_W'(1);
                end
            end
            DEC: begin
                w_state_nxt = CHECK;
            end
            DONE: begin
                if (r_result_valid && bus.result_ready) begin
                    w_state_nxt        = IDLE;
                    w_result_valid_nxt = 1'b0;
                end
            end
            ERR: begin
                if (bus.start) begin
                    w_state_nxt      = INIT;
                    w_err_nxt        = 1'b0;
                    w_iter_count_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        case (w_state_nxt)
            INIT: begin
                w_dp_rst_nxt = 1'b1;
                w_busy_nxt   = 1'b1;
            end
            CHECK: begin
                w_busy_nxt = 1'b1;
            end
            MUL: begin
                w_busy_nxt   = 1'b1;
                w_w_en_nxt   = 1'b1;
                w_a_sel_nxt  = 2'd0;
                w_b_sel_nxt  = 2'd1;
                w_op_sel_nxt = 1'b0;
                w_w_sel_nxt  = 1'b0;
            end
            DEC: begin
                w_busy_nxt   = 1'b1;
                w_w_en_nxt   = 1'b1;
                w_a_sel_nxt  = 2'd1;
                w_b_sel_nxt  = 2'd2;
                w_op_sel_nxt = 1'b1;
                w_w_sel_nxt  = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    assign bus.dp_rst       = r_dp_rst;
    assign bus.a_sel        = r_a_sel;
    assign bus.b_sel        = r_b_sel;
    assign bus.w_sel        = r_w_sel;
    assign bus.w_en         = r_w_en;
    assign bus.op_sel       = r_op_sel;
    assign bus.busy         = r_busy;
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
    assign bus.err          = r_err;
    assign bus.iter_count   = r_iter_count;
endmodule

// File: tb/tb_factorial_ctrl.sv
// Directed bench for factorial_ctrl with a small behavioural datapath (x0, x1, x2 = 1).
module tb_factorial_ctrl;
    localparam int unsigned MAX_ITER = 4;
    localparam int unsigned ITER_W   = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    factorial_ctrl_if #(.ITER_W(ITER_W)) bus ();

    factorial_ctrl #(.MAX_ITER(MAX_ITER), .ITER_W(ITER_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int ncmp  = 0;
    int nfail = 0;

    logic [31:0] x0;
    logic [31:0] x1;
    logic [31:0] n_val;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic        z_tied0;

    // Behavioural ALU
    always_comb begin
        case (bus.a_sel)
            2'd0:    alu_a = x0;
            2'd1:    alu_a = x1;
            2'd2:    alu_a = 32'd1;
            default: alu_a = 32'd0;
        endcase
        case (bus.b_sel)
            2'd0:    alu_b = x0;
            2'd1:    alu_b = x1;
            2'd2:    alu_b = 32'd1;
            default: alu_b = 32'd0;
        endcase
        alu_y = bus.op_sel ? (alu_a - alu_b) : (alu_a * alu_b);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (bus.dp_rst) begin
            x0 <= 32'd1;
            x1 <= n_val;
        end else if (bus.w_en) begin
            if (bus.w_sel) x1 <= alu_y;
            else           x0 <= alu_y;
        end
    end

    assign bus.z         = z_tied0 ? 1'b0 : (x1 == 32'd1);
    assign bus.dp_result = x0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ph: 0 = no write, 1 = MUL pattern, 2 = DEC pattern
    task automatic check_ctrl(input string tag, input int ph);
        logic [31:0] e_wen, e_a, e_b, e_op, e_ws;
        e_wen = 0; e_a = 0; e_b = 0; e_op = 0; e_ws = 0;
        if (ph == 1) begin
            e_wen = 1; e_a = 0; e_b = 1; e_op = 0; e_ws = 0;
        end else if (ph == 2) begin
            e_wen = 1; e_a = 1; e_b = 2; e_op = 1; e_ws = 1;
        end
        chk({tag, "_w_en"},   32'(bus.w_en),   e_wen);
        chk({tag, "_a_sel"},  32'(bus.a_sel),  e_a);
        chk({tag, "_b_sel"},  32'(bus.b_sel),  e_b);
        chk({tag, "_op_sel"}, 32'(bus.op_sel), e_op);
        chk({tag, "_w_sel"},  32'(bus.w_sel),  e_ws);
    endtask

    // Caller raises start; returns the cycle index (INIT = 1) where result_valid is first seen
    task automatic run(input bit do_phase, output int cyc, output int wen_cnt);
        tick;
        bus.start = 1'b0;
        cyc     = 1;
        wen_cnt = 0;
        while (bus.result_valid !== 1'b1 && cyc < 200) begin
            if (bus.w_en === 1'b1) wen_cnt++;
            if (do_phase) begin
                if (cyc == 1) begin
                    check_ctrl("init", 0);
                    chk("init_dp_rst", 32'(bus.dp_rst), 32'd1);
                end else begin
                    case ((cyc - 2) % 3)
                        0:       check_ctrl("check", 0);
                        1:       check_ctrl("mul", 1);
                        default: check_ctrl("dec", 2);
                    endcase
                    chk("run_dp_rst", 32'(bus.dp_rst), 32'd0);
                end
                chk("run_busy", 32'(bus.busy), 32'd1);
            end
            tick;
            cyc++;
        end
        chk("valid_seen", 32'(bus.result_valid), 32'd1);
    endtask

    initial begin
        int cyc;
        int wen;
        int muls;

        rst              = 1'b0;
        bus.start        = 1'b0;
        bus.result_ready = 1'b1;
        n_val            = 32'd5;
        z_tied0          = 1'b0;

        // Reset values
        #12;
        chk("rst_dp_rst", 32'(bus.dp_rst), 32'd1);
        chk("rst_valid",  32'(bus.result_valid), 32'd0);
        chk("rst_err",    32'(bus.err), 32'd0);
        chk("rst_iter",   32'(bus.iter_count), 32'd0);
        chk("rst_busy",   32'(bus.busy), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        check_ctrl("rst", 0);
        @(negedge clk);
        rst = 1'b1;
        tick;
        chk("post_rst_dp_rst", 32'(bus.dp_rst), 32'd0);
        check_ctrl("idle", 0);

        // 5! with latency and per-state control decode
        bus.start = 1'b1;
        run(1'b1, cyc, wen);
        chk("t1_latency", 32'(cyc), 32'd15);
        chk("t1_result",  bus.result, 32'd120);
        chk("t1_iter",    32'(bus.iter_count), 32'd4);
        chk("t1_busy",    32'(bus.busy), 32'd0);
        chk("t1_wen_cnt", 32'(wen), 32'd8);
        check_ctrl("done", 0);
        tick;
        chk("t1_ack_valid", 32'(bus.result_valid), 32'd0);
        chk("t1_ack_busy",  32'(bus.busy), 32'd0);

        // Back-pressure in DONE; start must be ignored
        bus.result_ready = 1'b0;
        bus.start        = 1'b1;
        run(1'b0, cyc, wen);
        chk("t2_result", bus.result, 32'd120);
        for (int i = 0; i < 10; i++) begin
            bus.start = (i == 2 || i == 6);
            tick;
            chk("t2_hold_valid",  32'(bus.result_valid), 32'd1);
            chk("t2_hold_result", bus.result, 32'd120);
            chk("t2_no_init",     32'(bus.dp_rst), 32'd0);
            chk("t2_no_busy",     32'(bus.busy), 32'd0);
        end
        bus.start        = 1'b0;
        bus.result_ready = 1'b1;
        tick;
        chk("t2_release_valid", 32'(bus.result_valid), 32'd0);
        chk("t2_release_busy",  32'(bus.busy), 32'd0);
        chk("t2_keep_result",   bus.result, 32'd120);
        tick;
        chk("t2_idle_dp_rst", 32'(bus.dp_rst), 32'd0);

        // Non-terminating run ends in ERR
        z_tied0   = 1'b1;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        cyc  = 1;
        muls = 0;
        while (bus.err !== 1'b1 && cyc < 100) begin
            if (bus.w_en === 1'b1 && bus.op_sel === 1'b0) muls++;
            tick;
            cyc++;
        end
        chk("t3_err",     32'(bus.err), 32'd1);
        chk("t3_latency", 32'(cyc), 32'd15);
        chk("t3_muls",    32'(muls), 32'd4);
        chk("t3_busy",    32'(bus.busy), 32'd0);
        chk("t3_iter",    32'(bus.iter_count), 32'd4);
        chk("t3_valid",   32'(bus.result_valid), 32'd0);
        check_ctrl("err", 0);
        tick;
        chk("t3_err_held",  32'(bus.err), 32'd1);
        chk("t3_iter_held", 32'(bus.iter_count), 32'd4);
        z_tied0   = 1'b0;
        bus.start = 1'b1;
        run(1'b1, cyc, wen);
        chk("t3_rerun_latency", 32'(cyc), 32'd15);
        chk("t3_rerun_result",  bus.result, 32'd120);
        chk("t3_rerun_err",     32'(bus.err), 32'd0);
        tick;

        // n = 1: immediate completion, no datapath writes
        n_val     = 32'd1;
        bus.start = 1'b1;
        run(1'b0, cyc, wen);
        chk("t4_latency", 32'(cyc), 32'd3);
        chk("t4_result",  bus.result, 32'd1);
        chk("t4_iter",    32'(bus.iter_count), 32'd0);
        chk("t4_wen_cnt", 32'(wen), 32'd0);
        tick;

        // Asynchronous reset during a MUL cycle
        n_val     = 32'd5;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        cyc = 0;
        while (!(bus.w_en === 1'b1 && bus.op_sel === 1'b0) && cyc < 20) begin
            tick;
            cyc++;
        end
        chk("t5_mul_seen", 32'(bus.w_en), 32'd1);
        rst = 1'b0;
        #1;
        chk("t5_w_en",   32'(bus.w_en), 32'd0);
        chk("t5_dp_rst", 32'(bus.dp_rst), 32'd1);
        chk("t5_busy",   32'(bus.busy), 32'd0);
        chk("t5_iter",   32'(bus.iter_count), 32'd0);
        chk("t5_valid",  32'(bus.result_valid), 32'd0);
        chk("t5_result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick;
        bus.start = 1'b1;
        run(1'b0, cyc, wen);
        chk("t5_rerun_result", bus.result, 32'd120);
        chk("t5_rerun_iter",   32'(bus.iter_count), 32'd4);
        tick;
        chk("t5_final_valid", 32'(bus.result_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
